decode_ex_pipe_reg: RTL and testbench

Decode-to-execute pipeline register. It sits directly downstream of the decode-stage operand forwarding logic. It captures the forwarded rs/rt operands and the decoded control for the execute stage. It also turns the load-use hazard flag into a one-cycle bubble, holds under a back-end stall, and squashes wrong-path instructions after a branch flush. Saturating stall and bubble counters are provided for performance analysis.

---
 rtl/decode_ex_pipe_reg.sv | 130 +++++++++++++
 tb/tb_decode_ex_pipe_reg.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/decode_ex_pipe_reg.sv
// rtl/decode_ex_pipe_reg.sv - decode-to-execute pipeline register with load-use bubble, stall hold and flush squash
module decode_ex_pipe_reg #(
  parameter int DATA_WIDTH    = 32,
  parameter int ALU_CTL_WIDTH = 4,
  parameter int FLUSH_SHADOW  = 1,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_dec_valid,
  input  logic [DATA_WIDTH-1:0]    i_rs_data,
  input  logic [DATA_WIDTH-1:0]    i_rt_data,
  input  logic [DATA_WIDTH-1:0]    i_imm,
  input  logic [DATA_WIDTH-1:0]    i_pc,
  input  logic [ALU_CTL_WIDTH-1:0] i_alu_ctl,
  input  logic [4:0]               i_rw_addr,
  input  logic                     i_uses_rw,
  input  logic                     i_is_mem_access,
  input  logic                     i_lw_hazard,
  input  logic                     i_ex_stall,
  input  logic                     i_flush,
  output logic                     o_dec_stall,
  output logic                     o_ex_valid,
  output logic [DATA_WIDTH-1:0]    o_rs_data,
  output logic [DATA_WIDTH-1:0]    o_rt_data,
  output logic [DATA_WIDTH-1:0]    o_imm,
  output logic [DATA_WIDTH-1:0]    o_pc,
  output logic [ALU_CTL_WIDTH-1:0] o_alu_ctl,
  output logic [4:0]               o_rw_addr,
  output logic                     o_uses_rw,
  output logic                     o_is_mem_access,
  output logic [CNT_WIDTH-1:0]     o_stall_cycles,
  output logic [CNT_WIDTH-1:0]     o_bubble_count
);

  localparam logic [2:0] SHADOW = 3'(FLUSH_SHADOW);

  typedef enum logic {RUN, SQUASH} state_e;

  state_e                   state_q, state_d;
  logic [2:0]               squash_q, squash_d;
  logic                     ex_valid_q, ex_valid_d;
  logic [CNT_WIDTH-1:0]     stall_q, stall_d;
  logic [CNT_WIDTH-1:0]     bubble_q, bubble_d;
  logic                     capture;
  logic [DATA_WIDTH-1:0]    rs_q, rt_q, imm_q, pc_q;
  logic [ALU_CTL_WIDTH-1:0] alu_ctl_q;
  logic [4:0]               rw_addr_q;
  logic                     uses_rw_q, is_mem_q;

  // Priority: flush, back-end stall, squash, load-use bubble, capture.
  always_comb begin
    state_d    = state_q;
    squash_d   = squash_q;
    ex_valid_d = ex_valid_q;
    bubble_d   = bubble_q;
    stall_d    = stall_q;
    capture    = 1'b0;
    if (i_ex_stall && stall_q != '1) stall_d = stall_q + 1'b1;
    if (i_flush) begin
      ex_valid_d = 1'b0;
      if (SHADOW != 3'd0) begin
        state_d  = SQUASH;
        squash_d = SHADOW;
      end
    end else if (i_ex_stall) begin
      ex_valid_d = ex_valid_q;
    end else if (state_q == SQUASH) begin
      ex_valid_d = 1'b0;
      squash_d   = squash_q - 3'd1;
      if (squash_q == 3'd1) state_d = RUN;
    end else if (i_lw_hazard && i_dec_valid) begin
      ex_valid_d = 1'b0;
      if (bubble_q != '1) bubble_d = bubble_q + 1'b1;
    end else begin
      ex_valid_d = i_dec_valid;
      capture    = 1'b1;
    end
  end

  // A squashed wrong-path instruction must drain out of decode, so no stall in SQUASH.
  assign o_dec_stall = ~i_flush & (i_ex_stall | ((state_q == RUN) & i_lw_hazard & i_dec_valid));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      squash_q   <= 3'd0;
      ex_valid_q <= 1'b0;
      stall_q    <= '0;
      bubble_q   <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      imm_q      <= '0;
      pc_q       <= '0;
      alu_ctl_q  <= '0;
      rw_addr_q  <= '0;
      uses_rw_q  <= 1'b0;
      is_mem_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      squash_q   <= squash_d;
      ex_valid_q <= ex_valid_d;
      stall_q    <= stall_d;
      bubble_q   <= bubble_d;
      if (capture) begin
        rs_q      <= i_rs_data;
        rt_q      <= i_rt_data;
        imm_q     <= i_imm;
        pc_q      <= i_pc;
        alu_ctl_q <= i_alu_ctl;
        rw_addr_q <= i_rw_addr;
        uses_rw_q <= i_uses_rw;
        is_mem_q  <= i_is_mem_access;
      end
    end
  end

  assign o_ex_valid      = ex_valid_q;
  assign o_rs_data       = rs_q;
  assign o_rt_data       = rt_q;
  assign o_imm           = imm_q;
  assign o_pc            = pc_q;
  assign o_alu_ctl       = alu_ctl_q;
  assign o_rw_addr       = rw_addr_q;
  assign o_uses_rw       = uses_rw_q;
  assign o_is_mem_access = is_mem_q;
  assign o_stall_cycles  = stall_q;
  assign o_bubble_count  = bubble_q;

endmodule

// File: tb/tb_decode_ex_pipe_reg.sv
// tb/tb_decode_ex_pipe_reg.sv - directed self-checking bench for decode_ex_pipe_reg
module tb_decode_ex_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid, uses_rw, is_mem, lw_hazard, ex_stall, flush;
  logic [31:0] rs, rt, imm, pc;
  logic [3:0]  alu_ctl;
  logic [4:0]  rw_addr;

  logic        dec_stall, ex_valid, o_uses_rw, o_is_mem;
  logic [31:0] o_rs, o_rt, o_imm, o_pc;
  logic [3:0]  o_alu_ctl;
  logic [4:0]  o_rw;
  logic [3:0]  stall_cnt, bubble_cnt;

  logic        z_dec_stall, z_ex_valid, z_uses_rw, z_is_mem;
  logic [31:0] z_rs, z_rt, z_imm, z_pc;
  logic [3:0]  z_alu_ctl;
  logic [4:0]  z_rw;
  logic [3:0]  z_stall_cnt, z_bubble_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  decode_ex_pipe_reg #(.DATA_WIDTH(32), .ALU_CTL_WIDTH(4), .FLUSH_SHADOW(2), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .i_dec_valid(dec_valid), .i_rs_data(rs), .i_rt_data(rt), .i_imm(imm),
    .i_pc(pc), .i_alu_ctl(alu_ctl), .i_rw_addr(rw_addr), .i_uses_rw(uses_rw),
    .i_is_mem_access(is_mem), .i_lw_hazard(lw_hazard), .i_ex_stall(ex_stall), .i_flush(flush),
    .o_dec_stall(dec_stall), .o_ex_valid(ex_valid), .o_rs_data(o_rs), .o_rt_data(o_rt),
    .o_imm(o_imm), .o_pc(o_pc), .o_alu_ctl(o_alu_ctl), .o_rw_addr(o_rw), .o_uses_rw(o_uses_rw),
    .o_is_mem_access(o_is_mem), .o_stall_cycles(stall_cnt), .o_bubble_count(bubble_cnt)
  );

  decode_ex_pipe_reg #(.DATA_WIDTH(32), .ALU_CTL_WIDTH(4), .FLUSH_SHADOW(0), .CNT_WIDTH(4)) dut_ns (
    .clk(clk), .rst(rst), .i_dec_valid(dec_valid), .i_rs_data(rs), .i_rt_data(rt), .i_imm(imm),
    .i_pc(pc), .i_alu_ctl(alu_ctl), .i_rw_addr(rw_addr), .i_uses_rw(uses_rw),
    .i_is_mem_access(is_mem), .i_lw_hazard(lw_hazard), .i_ex_stall(ex_stall), .i_flush(flush),
    .o_dec_stall(z_dec_stall), .o_ex_valid(z_ex_valid), .o_rs_data(z_rs), .o_rt_data(z_rt),
    .o_imm(z_imm), .o_pc(z_pc), .o_alu_ctl(z_alu_ctl), .o_rw_addr(z_rw), .o_uses_rw(z_uses_rw),
    .o_is_mem_access(z_is_mem), .o_stall_cycles(z_stall_cnt), .o_bubble_count(z_bubble_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] r_s, input logic [31:0] r_t, input logic [31:0] p,
                           input logic [4:0] rw);
    dec_valid = 1'b1;
    rs = r_s; rt = r_t; pc = p; rw_addr = rw;
    imm = p + 32'h8; alu_ctl = 4'h3; uses_rw = 1'b1; is_mem = 1'b0;
  endtask

  initial begin
    rst = 1'b1; dec_valid = 0; uses_rw = 0; is_mem = 0; lw_hazard = 0; ex_stall = 0; flush = 0;
    rs = 0; rt = 0; imm = 0; pc = 0; alu_ctl = 0; rw_addr = 0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("reset_valid", ex_valid, 0);
    check("reset_rs", o_rs, 0);
    check("reset_pc", o_pc, 0);
    check("reset_uses_rw", o_uses_rw, 0);
    check("reset_stall_cnt", stall_cnt, 0);
    check("reset_bubble_cnt", bubble_cnt, 0);
    check("reset_dec_stall", dec_stall, 0);

    set_instr(32'h11, 32'h22, 32'h100, 5'd5);
    #1 check("cap_dec_stall", dec_stall, 0);
    tick();
    check("cap_valid", ex_valid, 1);
    check("cap_rs", o_rs, 32'h11);
    check("cap_rt", o_rt, 32'h22);
    check("cap_rw", o_rw, 5);
    check("cap_uses_rw", o_uses_rw, 1);
    check("cap_imm", o_imm, 32'h108);
    check("cap_dec_stall_after", dec_stall, 0);

    set_instr(32'h33, 32'h34, 32'h104, 5'd6);
    lw_hazard = 1'b1;
    #1 check("haz_dec_stall", dec_stall, 1);
    tick();
    check("haz_bubble_valid", ex_valid, 0);
    check("haz_bubble_cnt", bubble_cnt, 1);
    check("haz_hold_rs", o_rs, 32'h11);
    lw_hazard = 1'b0;
    #1 check("haz_release_dec_stall", dec_stall, 0);
    tick();
    check("haz_capture_valid", ex_valid, 1);
    check("haz_capture_rs", o_rs, 32'h33);
    check("haz_capture_rw", o_rw, 6);

    set_instr(32'h44, 32'h45, 32'h400, 5'd7);
    tick();
    check("pre_stall_pc", o_pc, 32'h400);
    set_instr(32'h55, 32'h56, 32'h500, 5'd8);
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_dec_stall", dec_stall, 1);
      tick();
      check("stall_hold_pc", o_pc, 32'h400);
      check("stall_hold_valid", ex_valid, 1);
    end
    check("stall_cnt_3", stall_cnt, 3);
    ex_stall = 1'b0;

    set_instr(32'h66, 32'h67, 32'h600, 5'd9);
    flush = 1'b1;
    #1 check("flush_dec_stall", dec_stall, 0);
    tick();
    check("flush_valid", ex_valid, 0);
    check("flush_hold_pc", o_pc, 32'h400);
    check("ns_flush_valid", z_ex_valid, 0);
    flush = 1'b0;
    lw_hazard = 1'b1;
    #1 check("squash1_dec_stall", dec_stall, 0);
    check("ns_run_dec_stall", z_dec_stall, 1);
    tick();
    check("squash1_valid", ex_valid, 0);
    check("squash1_bubble_cnt", bubble_cnt, 1);
    lw_hazard = 1'b0;
    tick();
    check("squash2_valid", ex_valid, 0);
    tick();
    check("post_squash_valid", ex_valid, 1);
    check("post_squash_pc", o_pc, 32'h600);

    set_instr(32'h70, 32'h71, 32'h700, 5'd10);
    flush = 1'b1; ex_stall = 1'b1; lw_hazard = 1'b1;
    #1 check("combo_dec_stall", dec_stall, 0);
    tick();
    check("combo_valid", ex_valid, 0);
    check("combo_bubble_cnt", bubble_cnt, 1);
    check("combo_stall_cnt", stall_cnt, 4);
    flush = 1'b0; ex_stall = 1'b0;
    #1 check("combo_in_squash_dec_stall", dec_stall, 0);
    lw_hazard = 1'b0;
    tick();
    check("squash_cnt1_valid", ex_valid, 0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_sq_valid", ex_valid, 0);
    check("rst_sq_pc", o_pc, 0);
    check("rst_sq_rs", o_rs, 0);
    check("rst_sq_stall_cnt", stall_cnt, 0);
    check("rst_sq_bubble_cnt", bubble_cnt, 0);
    set_instr(32'h77, 32'h78, 32'h800, 5'd11);
    lw_hazard = 1'b1;
    #1 check("rst_sq_run_dec_stall", dec_stall, 1);
    lw_hazard = 1'b0;
    tick();
    check("rst_sq_capture_valid", ex_valid, 1);
    check("rst_sq_capture_rs", o_rs, 32'h77);

    dec_valid = 1'b0;
    lw_hazard = 1'b1;
    #1 check("haz_novalid_dec_stall", dec_stall, 0);
    tick();
    check("haz_novalid_valid", ex_valid, 0);
    check("haz_novalid_bubble_cnt", bubble_cnt, 0);
    lw_hazard = 1'b0;

    ex_stall = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("sat_stall_cnt_15", stall_cnt, 15);
    for (int i = 0; i < 5; i++) tick();
    check("sat_stall_cnt_hold", stall_cnt, 15);
    ex_stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
